// File: rtl/bp_cfg_loader.sv
// bp_cfg_loader: boot-time initiator for a tile's config-register responder.
// Freezes the tile, programs icache/dcache modes, streams CCE microcode from a
// synchronous ROM into the ucode window, programs CCE mode and unfreezes.
// Only one command is ever outstanding.
// Build option: define BP_CFG_LOADER_VERIFY_EN to read back every ucode word
// after writing it; a mismatch parks the loader in ERROR with the tile frozen.
module bp_cfg_loader #(
    parameter int unsigned cfg_addr_width_p  = 16,
    parameter int unsigned cfg_data_width_p  = 64,
    parameter int unsigned cce_pc_width_p    = 8,
    parameter int unsigned cce_instr_width_p = 48,
    parameter int unsigned ucode_els_p       = 256,
    parameter logic [cfg_addr_width_p-1:0] ucode_base_p       = 16'h8000,
    parameter logic [cfg_addr_width_p-1:0] freeze_addr_p      = 16'h0002,
    parameter logic [cfg_addr_width_p-1:0] icache_mode_addr_p = 16'h0022,
    parameter logic [cfg_addr_width_p-1:0] dcache_mode_addr_p = 16'h0043,
    parameter logic [cfg_addr_width_p-1:0] cce_mode_addr_p    = 16'h0081,
    parameter int unsigned lce_mode_p        = 1,
    parameter int unsigned cce_mode_p        = 1
) (
    input  logic                          clk_i,
    input  logic                          reset_n_i,
    input  logic                          start_i,
    output logic                          busy_o,
    output logic                          done_o,
    output logic                          error_o,
    output logic [cce_pc_width_p-1:0]     rom_addr_o,
    input  logic [cce_instr_width_p-1:0]  rom_data_i,
    output logic                          mem_cmd_v_o,
    input  logic                          mem_cmd_ready_i,
    output logic                          mem_cmd_w_o,
    output logic [cfg_addr_width_p-1:0]   mem_cmd_addr_o,
    output logic [cfg_data_width_p-1:0]   mem_cmd_data_o,
    input  logic                          mem_resp_v_i,
    output logic                          mem_resp_yumi_o,
    input  logic [cfg_data_width_p-1:0]   mem_resp_data_i
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ROM_RD,
        ST_SEND,
        ST_WAIT,
        ST_DONE,
        ST_ERROR
    } state_e;

    typedef enum logic [2:0] {
        STEP_FRZ,
        STEP_ICM,
        STEP_DCM,
        STEP_UC,
        STEP_CCM,
        STEP_UFRZ
    } step_e;

    // One extra counter bit lets a full 2^cce_pc_width_p image terminate cleanly.
    localparam int unsigned wd_width_lp  = cce_pc_width_p + 1;
    localparam logic [wd_width_lp-1:0] last_wd_lp = wd_width_lp'(ucode_els_p - 1);
    localparam int unsigned pad_width_lp = cfg_data_width_p - cce_instr_width_p;

    state_e                         state_reg, state_next;
    step_e                          step_reg, step_next;
    logic [wd_width_lp-1:0]         wd_reg, wd_next;
    logic [cce_instr_width_p-1:0]   word_reg, word_next;
    // Set for the first SEND cycle after ROM_RD, when rom_data_i holds the word.
    logic                           cap_reg, cap_next;
    logic [cce_instr_width_p-1:0]   ucode_word;
`ifdef BP_CFG_LOADER_VERIFY_EN
    // Set while the outstanding ucode command is the readback.
    logic                           rd_reg, rd_next;
    logic                           unused_resp;
    assign unused_resp = ^mem_resp_data_i[cfg_data_width_p-1:cce_instr_width_p];
`else
    logic                           unused_resp;
    assign unused_resp = ^mem_resp_data_i;
`endif

    // The ROM word is presented live in its capture cycle, then from the hold register.
    assign ucode_word = cap_reg ? rom_data_i : word_reg;
    assign rom_addr_o = wd_reg[cce_pc_width_p-1:0];

    assign mem_cmd_v_o = (state_reg == ST_SEND);
    assign busy_o      = (state_reg == ST_ROM_RD) || (state_reg == ST_SEND) ||
                         (state_reg == ST_WAIT);
    assign done_o      = (state_reg == ST_DONE);
`ifdef BP_CFG_LOADER_VERIFY_EN
    assign error_o     = (state_reg == ST_ERROR);
    assign mem_cmd_w_o = ~rd_reg;
`else
    assign error_o     = 1'b0;
    assign mem_cmd_w_o = 1'b1;
`endif

    // State, step, word counter and held ucode word; reset aborts any sequence.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_reg <= ST_IDLE;
            step_reg  <= STEP_FRZ;
            wd_reg    <= '0;
            word_reg  <= '0;
            cap_reg   <= 1'b0;
`ifdef BP_CFG_LOADER_VERIFY_EN
            rd_reg    <= 1'b0;
`endif
        end else begin
            state_reg <= state_next;
            step_reg  <= step_next;
            wd_reg    <= wd_next;
            word_reg  <= word_next;
            cap_reg   <= cap_next;
`ifdef BP_CFG_LOADER_VERIFY_EN
            rd_reg    <= rd_next;
`endif
        end
    end

    // Next-state logic: walk the step list, one command and one response at a time.
    always_comb begin
        state_next      = state_reg;
        step_next       = step_reg;
        wd_next         = wd_reg;
        word_next       = word_reg;
        cap_next        = cap_reg;
`ifdef BP_CFG_LOADER_VERIFY_EN
        rd_next         = rd_reg;
`endif
        mem_resp_yumi_o = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (start_i) begin
                    state_next = ST_SEND;
                    step_next  = STEP_FRZ;
                    wd_next    = '0;
                    cap_next   = 1'b0;
                end
            end
            ST_ROM_RD: begin
                state_next = ST_SEND;
                cap_next   = 1'b1;
            end
            ST_SEND: begin
                // Capture on the first SEND cycle whether or not the responder is ready.
                if (cap_reg) begin
                    word_next = rom_data_i;
                    cap_next  = 1'b0;
                end
                if (mem_cmd_ready_i) begin
                    state_next = ST_WAIT;
                end
            end
            ST_WAIT: begin
                mem_resp_yumi_o = mem_resp_v_i;
                if (mem_resp_v_i) begin
                    case (step_reg)
                        STEP_FRZ: begin
                            step_next  = STEP_ICM;
                            state_next = ST_SEND;
                        end
                        STEP_ICM: begin
                            step_next  = STEP_DCM;
                            state_next = ST_SEND;
                        end
                        STEP_DCM: begin
                            step_next  = STEP_UC;
                            wd_next    = '0;
                            state_next = ST_ROM_RD;
                        end
                        STEP_UC: begin
`ifdef BP_CFG_LOADER_VERIFY_EN
                            rd_next = ~rd_reg;
                            if (!rd_reg) begin
                                state_next = ST_SEND;
                            end else if (mem_resp_data_i[cce_instr_width_p-1:0] != word_reg) begin
                                state_next = ST_ERROR;
                            end else
`endif
                            begin
                                if (wd_reg == last_wd_lp) begin
                                    step_next  = STEP_CCM;
                                    state_next = ST_SEND;
                                end else begin
                                    wd_next    = wd_reg + 1'b1;
                                    state_next = ST_ROM_RD;
                                end
                            end
                        end
                        STEP_CCM: begin
                            step_next  = STEP_UFRZ;
                            state_next = ST_SEND;
                        end
                        STEP_UFRZ: begin
                            state_next = ST_DONE;
                        end
                        default: begin
                            state_next = ST_IDLE;
                        end
                    endcase
                end
            end
            ST_DONE: begin
                state_next = ST_DONE;
            end
            ST_ERROR: begin
                state_next = ST_ERROR;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Command address/data are pure functions of the step, so they hold while stalled.
    always_comb begin
        mem_cmd_addr_o = '0;
        mem_cmd_data_o = '0;
        case (step_reg)
            STEP_FRZ: begin
                mem_cmd_addr_o = freeze_addr_p;
                mem_cmd_data_o = cfg_data_width_p'(1);
            end
            STEP_ICM: begin
                mem_cmd_addr_o = icache_mode_addr_p;
                mem_cmd_data_o = cfg_data_width_p'(lce_mode_p);
            end
            STEP_DCM: begin
                mem_cmd_addr_o = dcache_mode_addr_p;
                mem_cmd_data_o = cfg_data_width_p'(lce_mode_p);
            end
            STEP_UC: begin
                mem_cmd_addr_o = ucode_base_p + cfg_addr_width_p'(wd_reg);
`ifdef BP_CFG_LOADER_VERIFY_EN
                if (!rd_reg) begin
                    mem_cmd_data_o = {{pad_width_lp{1'b0}}, ucode_word};
                end
`else
                mem_cmd_data_o = {{pad_width_lp{1'b0}}, ucode_word};
`endif
            end
            STEP_CCM: begin
                mem_cmd_addr_o = cce_mode_addr_p;
                mem_cmd_data_o = cfg_data_width_p'(cce_mode_p);
            end
            STEP_UFRZ: begin
                mem_cmd_addr_o = freeze_addr_p;
                mem_cmd_data_o = '0;
            end
            default: begin
                mem_cmd_addr_o = '0;
                mem_cmd_data_o = '0;
            end
        endcase
    end

`ifndef SYNTHESIS
    // A response with no command waiting for it means the responder broke protocol.
    resp_only_in_wait: assert property (@(posedge clk_i) disable iff (!reset_n_i)
        mem_resp_v_i |-> (state_reg == ST_WAIT));
`endif

endmodule

// File: tb/tb_bp_cfg_loader.sv
// Testbench for bp_cfg_loader with a 4-word ucode image and a behavioural
// config responder (configurable ready stall, response delay and readback fault).
module tb_bp_cfg_loader;

    logic        clk_i   = 1'b0;
    logic        reset_n = 1'b0;
    logic        start   = 1'b0;
    logic        busy;
    logic        done;
    logic        err;
    logic [7:0]  rom_addr;
    logic [47:0] rom_data;
    logic        cmd_v;
    logic        cmd_ready = 1'b1;
    logic        cmd_w;
    logic [15:0] cmd_addr;
    logic [63:0] cmd_data;
    logic        resp_v;
    logic        resp_yumi;
    logic [63:0] resp_data;

    // Responder / ROM knobs driven by the stimulus process
    int          resp_delay = 0;
    logic [15:0] bad_addr   = 16'hFFFF;
    logic        rom_glitch = 1'b0;

    // Responder-internal state
    int          wait_cnt;
    logic [63:0] last_wdata;

    // Transaction log
    logic [15:0] log_addr [$];
    logic [63:0] log_data [$];
    bit          log_w    [$];

    int vec_count   = 0;
    int miscompares = 0;

    logic [15:0] exp_addr [0:8] = '{16'h0002, 16'h0022, 16'h0043,
                                    16'h8000, 16'h8001, 16'h8002, 16'h8003,
                                    16'h0081, 16'h0002};
    logic [63:0] exp_data [0:8] = '{64'h1, 64'h1, 64'h1,
                                    64'h1000, 64'h1001, 64'h1002, 64'h1003,
                                    64'h1, 64'h0};

`ifdef BP_CFG_LOADER_VERIFY_EN
    localparam int seq_cycles = 2 + 2 + 2 + 4 * 5 + 2 + 2;
    localparam int aborted_cmds = 5;
`else
    localparam int seq_cycles = 2 + 2 + 2 + 4 * 3 + 2 + 2;
    localparam int aborted_cmds = 4;
`endif

    bp_cfg_loader #(
        .ucode_els_p(4)
    ) dut (
        .clk_i           (clk_i),
        .reset_n_i       (reset_n),
        .start_i         (start),
        .busy_o          (busy),
        .done_o          (done),
        .error_o         (err),
        .rom_addr_o      (rom_addr),
        .rom_data_i      (rom_data),
        .mem_cmd_v_o     (cmd_v),
        .mem_cmd_ready_i (cmd_ready),
        .mem_cmd_w_o     (cmd_w),
        .mem_cmd_addr_o  (cmd_addr),
        .mem_cmd_data_o  (cmd_data),
        .mem_resp_v_i    (resp_v),
        .mem_resp_yumi_o (resp_yumi),
        .mem_resp_data_i (resp_data)
    );

    always #5 clk_i = ~clk_i;

    // Synchronous ROM: word i = 0x1000 + i, one cycle of latency.
    always @(posedge clk_i) begin
        rom_data <= rom_glitch ? 48'hBAD0 : (48'h1000 + {40'h0, rom_addr});
    end

    // Config responder: logs each handshake, answers after resp_delay extra cycles.
    always @(posedge clk_i or negedge reset_n) begin
        if (!reset_n) begin
            resp_v     <= 1'b0;
            resp_data  <= '0;
            wait_cnt   <= 0;
            last_wdata <= '0;
        end else begin
            if (resp_v && resp_yumi) resp_v <= 1'b0;
            if (wait_cnt != 0) begin
                if (wait_cnt == 1) resp_v <= 1'b1;
                wait_cnt <= wait_cnt - 1;
            end
            if (cmd_v && cmd_ready) begin
                log_addr.push_back(cmd_addr);
                log_data.push_back(cmd_data);
                log_w.push_back(cmd_w);
                $display("[%0t] cmd %s addr=%h data=%h", $time, cmd_w ? "WR" : "RD",
                         cmd_addr, cmd_data);
                if (cmd_w) begin
                    last_wdata <= cmd_data;
                    resp_data  <= '0;
                end else begin
                    resp_data  <= (cmd_addr == bad_addr) ? 64'hDEAD : last_wdata;
                end
                if (resp_delay == 0) resp_v <= 1'b1;
                else wait_cnt <= resp_delay;
            end
        end
    end

    task automatic check_vec(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vec_count++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        reset_n    = 1'b0;
        start      = 1'b0;
        cmd_ready  = 1'b1;
        resp_delay = 0;
        bad_addr   = 16'hFFFF;
        rom_glitch = 1'b0;
        repeat (3) @(negedge clk_i);
        reset_n = 1'b1;
        @(negedge clk_i);
    endtask

    task automatic pulse_start();
        @(negedge clk_i);
        start = 1'b1;
        @(posedge clk_i);
        @(negedge clk_i);
        start = 1'b0;
    endtask

    // Counts rising edges until done/error, bounded.
    task automatic wait_done(output int cycles);
        cycles = 0;
        while (!done && !err && cycles < 500) begin
            @(posedge clk_i);
            cycles++;
            @(negedge clk_i);
        end
    endtask

    task automatic wait_cmd(input logic [15:0] a);
        int n;
        n = 0;
        while (!(cmd_v && cmd_addr == a) && n < 300) begin
            @(negedge clk_i);
            n++;
        end
        check_vec($sformatf("cmd_seen_%h", a), {63'h0, cmd_v && (cmd_addr == a)}, 64'h1);
    endtask

    // Compares the writes logged since index base against the boot sequence.
    task automatic check_log(input int base);
        int nwr;
        nwr = 0;
        for (int i = base; i < log_addr.size(); i++) begin
            if (log_w[i]) begin
                if (nwr < 9) begin
                    check_vec($sformatf("wr%0d_addr", nwr), {48'h0, log_addr[i]}, {48'h0, exp_addr[nwr]});
                    check_vec($sformatf("wr%0d_data", nwr), log_data[i], exp_data[nwr]);
                end
                nwr++;
            end
        end
        check_vec("wr_count", nwr, 9);
    endtask

    initial begin
        int cyc;
        int base;
        int bad;
        int n;

        // ---- reset state
        repeat (2) @(negedge clk_i);
        check_vec("rst_busy", busy, 0);
        check_vec("rst_done", done, 0);
        check_vec("rst_error", err, 0);
        check_vec("rst_cmd_v", cmd_v, 0);
        check_vec("rst_yumi", resp_yumi, 0);
        check_vec("rst_rom_addr", rom_addr, 0);
        do_reset();

        // ---- full sequence, start held high throughout and past DONE
        base = log_addr.size();
        @(negedge clk_i);
        start = 1'b1;
        @(posedge clk_i);
        wait_done(cyc);
        check_vec("done_reached", done, 1);
        check_vec("done_latency", cyc, seq_cycles);
        check_vec("done_busy", busy, 0);
        repeat (10) @(negedge clk_i);
        start = 1'b0;
        check_vec("done_sticky", done, 1);
        check_vec("no_restart_cmd_v", cmd_v, 0);
        check_log(base);

        // ---- ready stall during UC[2]; ROM output corrupted after capture
        do_reset();
        base = log_addr.size();
        pulse_start();
        wait_cmd(16'h8002);
        cmd_ready  = 1'b0;
        rom_glitch = 1'b1;
        check_vec("stall1_data", cmd_data, 64'h1002);
        bad = 0;
        for (int k = 2; k <= 6; k++) begin
            @(posedge clk_i);
            @(negedge clk_i);
            if (!(cmd_v && cmd_addr == 16'h8002 && cmd_data == 64'h1002)) bad++;
        end
        check_vec("stall_fields_stable", bad, 0);
        cmd_ready  = 1'b1;
        rom_glitch = 1'b0;
        wait_done(cyc);
        check_vec("stall_done", done, 1);
        n = 0;
        for (int i = base; i < log_addr.size(); i++)
            if (log_w[i] && log_addr[i] == 16'h8002) n++;
        check_vec("stall_no_dup", n, 1);
        check_log(base);

        // ---- delayed response after FRZ
        do_reset();
        base = log_addr.size();
        resp_delay = 10;
        pulse_start();
        n = 0;
        while (log_addr.size() == base && n < 20) begin
            @(negedge clk_i);
            n++;
        end
        resp_delay = 0;
        bad = 0;
        n = 0;
        while (!resp_v && n < 40) begin
            if (cmd_v || resp_yumi) bad++;
            @(posedge clk_i);
            @(negedge clk_i);
            n++;
        end
        check_vec("delay_resp_seen", resp_v, 1);
        check_vec("delay_yumi_on_resp", resp_yumi, 1);
        check_vec("delay_quiet_wait", bad, 0);
        check_vec("delay_wait_cycles", n, 10);
        check_vec("delay_one_cmd", log_addr.size() - base, 1);
        wait_done(cyc);
        check_log(base);

        // ---- reset during UC[1] SEND, then restart
        do_reset();
        base = log_addr.size();
        pulse_start();
        wait_cmd(16'h8001);
        #2 reset_n = 1'b0;
        #1;
        check_vec("abort_cmd_v", cmd_v, 0);
        check_vec("abort_busy", busy, 0);
        check_vec("aborted_cmds", log_addr.size() - base, aborted_cmds);
        @(negedge clk_i);
        @(negedge clk_i);
        reset_n = 1'b1;
        @(negedge clk_i);
        base = log_addr.size();
        pulse_start();
        wait_done(cyc);
        check_vec("restart_done", done, 1);
        check_log(base);

`ifdef BP_CFG_LOADER_VERIFY_EN
        // ---- readback mismatch on 0x8001
        do_reset();
        base = log_addr.size();
        bad_addr = 16'h8001;
        pulse_start();
        wait_done(cyc);
        check_vec("vfy_error", err, 1);
        check_vec("vfy_done", done, 0);
        check_vec("vfy_busy", busy, 0);
        bad = 0;
        repeat (10) begin
            @(negedge clk_i);
            if (cmd_v) bad++;
        end
        check_vec("vfy_quiet", bad, 0);
        n = 0;
        for (int i = base; i < log_addr.size(); i++)
            if (log_w[i] && (log_addr[i] == 16'h0081 ||
                             (log_addr[i] == 16'h0002 && log_data[i] == 64'h0))) n++;
        check_vec("vfy_no_ccm_ufrz", n, 0);
        check_vec("vfy_error_sticky", err, 1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
        $finish;
    end

endmodule
